// File: rtl/multdiv_seq.sv
// multdiv_seq: iterative signed 32-bit multiply / divide, one bit per cycle.
// A start pulse captures operand magnitudes and the result sign. The unit
// iterates for 32 cycles and loads the result on entry to DONE, which is
// 33 cycles after the start edge. A start in any state restarts the unit.
//
// Ports
//   clock           in   master clock, rising edge
//   reset           in   synchronous, active-high
//   data_operandA   in   32  multiplicand / dividend (sampled on start)
//   data_operandB   in   32  multiplier / divisor   (sampled on start)
//   ctrl_MULT       in   start multiply (wins over ctrl_DIV)
//   ctrl_DIV        in   start divide
//   data_result     out  32  registered result, held until the next completion
//   data_exception  out  overflow / divide-by-zero / unrepresentable quotient
//   data_resultRDY  out  one-cycle completion strobe (DONE state)
//   busy            out  high in MULT, DIV and DONE
//
// state | meaning
// IDLE  | waiting for a start, outputs hold
// MULT  | shift-add multiply iterations, then finalize
// DIV   | restoring divide iterations, then finalize
// DONE  | result valid, RDY high for this one cycle
module multdiv_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic        r_sign;
  logic [31:0] r_mag_a;
  logic [31:0] r_mag_b;
  logic [63:0] r_work;
  logic        r_div_zero;
  logic        r_div_ovf;
  logic [31:0] r_result;
  logic        r_exception;

  logic        w_start;
  logic        w_last;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_madd;
  logic [63:0] w_mul_nxt;
  logic [63:0] w_shift;
  logic [32:0] w_trial;
  logic [63:0] w_div_nxt;
  logic [63:0] w_prod_s;
  logic        w_mul_exc;
  logic [31:0] w_quo_s;

  assign w_start = ctrl_MULT | ctrl_DIV;
  // Counter reaches 32 after the last iteration; the following edge finalizes.
  assign w_last  = (r_cnt == 6'd32);

  assign w_abs_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign w_abs_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  // Multiply step: conditionally add |A| into the upper half, keep the carry,
  // and shift the whole register right by one.
  assign w_madd    = {1'b0, r_work[63:32]} + (r_work[0] ? {1'b0, r_mag_a} : 33'd0);
  assign w_mul_nxt = {w_madd, r_work[31:1]};

  // Divide step: remainder stays below 2*|B| <= 2^32 so 32 bits suffice;
  // the 33rd bit of the trial is only the borrow.
  assign w_shift   = {r_work[62:0], 1'b0};
  assign w_trial   = {1'b0, w_shift[63:32]} - {1'b0, r_mag_b};
  assign w_div_nxt = w_trial[32] ? w_shift : {w_trial[31:0], w_shift[31:1], 1'b1};

  assign w_prod_s  = r_sign ? (64'd0 - r_work) : r_work;
  assign w_mul_exc = ~((&w_prod_s[63:31]) | ~(|w_prod_s[63:31]));
  assign w_quo_s   = r_sign ? (32'd0 - r_work[31:0]) : r_work[31:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ctrl_MULT ? S_MULT : S_DIV;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_MULT:  w_state_nxt = w_last ? S_DONE : S_MULT;
        S_DIV:   w_state_nxt = w_last ? S_DONE : S_DIV;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy           = (r_state != S_IDLE);
    data_resultRDY = (r_state == S_DONE);
  end

  // Datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt       <= 6'd0;
      r_sign      <= 1'b0;
      r_mag_a     <= 32'd0;
      r_mag_b     <= 32'd0;
      r_work      <= 64'd0;
      r_div_zero  <= 1'b0;
      r_div_ovf   <= 1'b0;
      r_result    <= 32'd0;
      r_exception <= 1'b0;
    end else if (w_start) begin
      r_cnt      <= 6'd0;
      r_sign     <= data_operandA[31] ^ data_operandB[31];
      r_mag_a    <= w_abs_a;
      r_mag_b    <= w_abs_b;
      r_work     <= {32'd0, (ctrl_MULT ? w_abs_b : w_abs_a)};
      r_div_zero <= (data_operandB == 32'd0);
      r_div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
    end else if (r_state == S_MULT) begin
      if (w_last) begin
        r_result    <= w_prod_s[31:0];
        r_exception <= w_mul_exc;
      end else begin
        r_work <= w_mul_nxt;
        r_cnt  <= r_cnt + 6'd1;
      end
    end else if (r_state == S_DIV) begin
      if (w_last) begin
        if (r_div_zero) begin
          r_result    <= 32'd0;
          r_exception <= 1'b1;
        end else if (r_div_ovf) begin
          r_result    <= 32'h8000_0000;
          r_exception <= 1'b1;
        end else begin
          r_result    <= w_quo_s;
          r_exception <= 1'b0;
        end
      end else begin
        r_work <= w_div_nxt;
        r_cnt  <= r_cnt + 6'd1;
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;

endmodule

// File: tb/tb_multdiv_seq.sv
// Testbench for multdiv_seq: directed cases plus randomized multiply/divide
// operations compared against an arithmetic reference model.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_res;
  logic        last_exc;

  multdiv_seq dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint sa, sb, p, hi, lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = (longint'(1) <<< 31) - 1;
    lo = -(longint'(1) <<< 31);
    if (!is_div) begin
      p = sa * sb;
      r = p[31:0];
      e = (p > hi) || (p < lo);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      p = sa / sb;
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  task automatic pulse(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    chk("busy_at_start", busy, 1);
    chk("rdy_at_start", data_resultRDY, 0);
  endtask

  // Called one step after the start edge E0; runs through E34.
  task automatic wait_done(input string tag, input logic [31:0] er, input logic ee);
    for (int k = 1; k <= 32; k++) begin
      data_operandA = $urandom;
      data_operandB = $urandom;
      tick();
      chk({tag, "_rdy_early"}, data_resultRDY, 0);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_res_hold"}, data_result, last_res);
      chk({tag, "_exc_hold"}, data_exception, last_exc);
    end
    tick();
    chk({tag, "_rdy"}, data_resultRDY, 1);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_res"}, data_result, er);
    chk({tag, "_exc"}, data_exception, ee);
    last_res = er;
    last_exc = ee;
    tick();
    chk({tag, "_rdy_after"}, data_resultRDY, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_res_after"}, data_result, er);
    chk({tag, "_exc_after"}, data_exception, ee);
  endtask

  task automatic run_op(input string tag, input bit is_div, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ee;
    model(is_div, a, b, er, ee);
    pulse(!is_div, is_div, a, b);
    wait_done(tag, er, ee);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3: begin
        v = $urandom_range(0, 40);
        if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_res", data_result, 0);
    chk("rst_exc", data_exception, 0);
    chk("rst_rdy", data_resultRDY, 0);
    chk("rst_busy", busy, 0);
    last_res = 32'd0;
    last_exc = 1'b0;
    tick();

    // Directed cases
    run_op("mul_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("mul_7x-3_val", last_res, 32'hFFFF_FFEB);
    run_op("mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000);
    run_op("mul_min", 1'b0, 32'hFFFF_0000, 32'h0000_8000);
    run_op("div_-21/4", 1'b1, 32'hFFFF_FFEB, 32'd4);
    run_op("div_100/7", 1'b1, 32'd100, 32'd7);
    run_op("div_by0", 1'b1, 32'd5, 32'd0);
    run_op("div_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

    // Abort: MULT 3x4 at E0, DIV 9/3 at E10 -> RDY only at E43 with 3
    pulse(1'b1, 1'b0, 32'd3, 32'd4);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("abort_rdy_pre", data_resultRDY, 0);
    end
    pulse(1'b0, 1'b1, 32'd9, 32'd3);
    wait_done("abort_div", 32'd3, 1'b0);

    // Both starts together: multiply wins
    pulse(1'b1, 1'b1, 32'd6, 32'd7);
    wait_done("both", 32'd42, 1'b0);

    // Reset at E15 of a multiply
    pulse(1'b1, 1'b0, 32'd5, 32'd6);
    for (int k = 1; k <= 14; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_res", data_result, 0);
    chk("midrst_exc", data_exception, 0);
    chk("midrst_rdy", data_resultRDY, 0);
    chk("midrst_busy", busy, 0);
    last_res = 32'd0;
    last_exc = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk("midrst_no_rdy", data_resultRDY, 0);
      chk("midrst_idle", busy, 0);
    end
    run_op("post_rst", 1'b0, 32'hFFFF_FFF9, 32'd9);

    // Reset wins over a simultaneous start
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    data_operandA = 32'd2;
    data_operandB = 32'd2;
    tick();
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_res", data_result, 0);
    last_res = 32'd0;
    last_exc = 1'b0;
    tick();
    chk("rst_prio_idle", busy, 0);

    // Randomized operations
    for (int i = 0; i < 50; i++) begin
      logic [31:0] a, b;
      bit          d;
      a = pick();
      b = pick();
      d = ($urandom_range(0, 1) == 1);
      run_op(d ? "rnd_div" : "rnd_mul", d, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Iterative signed 32-bit multiply/divide unit consumed by the execute stage of the 5-stage pipeline. It starts on a one-cycle `ctrl_MULT` or `ctrl_DIV` pulse and captures its operands internally. It iterates one bit per cycle and returns a registered result with a one-cycle `data_resultRDY` strobe. The execute stage stalls the pipeline until that strobe, then latches `data_result` and `data_exception` into the X/M latch.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- `clock`  in  1  master clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous and active-high; forces IDLE and clears all outputs on the next rising edge.
- `data_operandA`  in  32  signed multiplicand / dividend; sampled only on the start edge.
- `data_operandB`  in  32  signed multiplier / divisor; sampled only on the start edge.
- `ctrl_MULT`  in  1  start-multiply pulse.
- `ctrl_DIV`  in  1  start-divide pulse.
- `data_result`  out  32  registered result; holds the last value until the next completion.
- `data_exception`  out  1  registered; overflow, div-by-zero or unrepresentable quotient.
- `data_resultRDY`  out  1  high for exactly one cycle when the result is valid.
- `busy`  out  1  high in MULT, DIV and DONE states.

## Operation
- States: IDLE, MULT, DIV, DONE. A 6-bit iteration counter, operand sign flags, magnitude registers and a 64-bit working register (product or {remainder, quotient}).
- Start edge: a rising edge with `ctrl_MULT` or `ctrl_DIV` high and `reset` low.
  - Latch `|A|` and `|B|` (two's-complement negate when negative).
  - Latch the result sign (`A[31]^B[31]`).
  - Clear the counter and enter MULT or DIV.
- If both starts are high on the same edge, MULT wins.
- A start received in any state, including MULT, DIV or DONE, aborts the current operation and restarts with new operands. No RDY is issued for the aborted operation.
- MULT:
  - Each cycle, if the multiplier LSB is set, add the multiplicand to the upper half.
  - Then shift the 64-bit register right by 1.
  - Runs for 32 cycles, then goes to DONE.
- DIV:
  - Restoring division: shift {rem, quo} left 1, then trial-subtract `|B|` from rem.
  - If the trial is non-negative, keep it and set quo LSB.
  - Runs for 32 cycles, then goes to DONE.
- Transition into DONE loads `data_result` and `data_exception` as follows.
  - **MULT**
    - Negate the 64-bit magnitude product if the sign flag is set.
    - `data_result` = low 32 bits.
    - `data_exception` = 1 unless bits [63:31] are all 0 or all 1.
  - **DIV, B = 0**
    - Result 0, exception 1.
  - **DIV, A = 0x80000000 and B = 0xFFFFFFFF**
    - Result 0x80000000, exception 1.
  - **DIV, all other cases**
    - Quotient truncated toward zero, negated if the sign flag is set; exception 0.
    - The remainder is discarded.
- DONE: `data_resultRDY`=1 for this one cycle. The next edge returns to IDLE unless a new start arrives.
- IDLE: `data_resultRDY`=0. `data_result` and `data_exception` hold their values.

## Timing
- Reset values:
  - state IDLE
  - `data_result`=0
  - `data_exception`=0
  - `data_resultRDY`=0
  - `busy`=0
- Reset mid-operation abandons the operation; no RDY is issued. Reset has priority over a simultaneous start.
- Latency: if start is sampled at edge E0, the iterations occupy E1..E32 and DONE is entered at E33. `data_resultRDY` is high from E33 to E34.
  - Fixed 33-cycle latency for every case, including divide-by-zero.
- `data_result` and `data_exception` change only on entry to DONE or on reset. They are stable for the whole RDY cycle and afterwards.
- `data_resultRDY` and `busy` are decoded from registered state, with no combinational path from any input.
- The caller may change the operands after E0 without affecting the result.
- The caller must not hold a start high continuously; every high edge restarts the operation.

## Test plan
- **Multiply:** A=7, B=-3, MULT pulse at E0.
  - `busy`=1 from E0.
  - RDY=1 only in the E33 cycle, with result 0xFFFFFFEB (-21) and exception 0.
  - Operands changed after E0 must not alter the result.
- **Multiply overflow:** A=0x00010000, B=0x00010000 → result 0x00000000, exception 1.
  - A=-65536, B=32768 → result 0x80000000, exception 0.
- **Divide, truncation toward zero:** A=-21, B=4 → result 0xFFFFFFFB (-5), exception 0.
  - A=100, B=7 → result 14.
- **Divide special cases:**
  - A=5, B=0 → result 0, exception 1, still at E33.
  - A=0x80000000, B=-1 → result 0x80000000, exception 1.
- **Abort and restart:** MULT 3×4 at E0, then DIV 9/3 at E10.
  - No RDY at E33.
  - RDY at E43 with result 3.
  - Both pulses high together → multiply is performed.
- **Reset:** assert `reset` for one edge at E15 of a multiply.
  - All outputs 0 and state IDLE.
  - No RDY is seen afterwards.
  - A subsequent start completes normally with 33-cycle latency.
